// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: result-select and ALU encodings plus the
// control-word layout carried from decode into execute.
package rv_pkg;

    localparam int RESULT_SRC_W  = 2;
    localparam int ALU_CTRL_W    = 4;
    localparam int FUNCT3_W      = 3;
    localparam int REG_IDX_W     = 5;

    typedef enum logic [RESULT_SRC_W-1:0] {
        RESULT_ALU  = 2'b00,
        RESULT_MEM  = 2'b01,
        RESULT_PC4  = 2'b10
    } result_src_e;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic                    branch;
        logic                    jump;
        logic                    jalr;
        logic                    alu_src;
        logic [RESULT_SRC_W-1:0] result_src;
        logic [ALU_CTRL_W-1:0]   alu_control;
    } ctrl_word_t;

    // A slot that is not a real instruction must not write, store or redirect.
    function automatic ctrl_word_t gate_ctrl(input ctrl_word_t cw, input logic valid);
        ctrl_word_t r;
        r = cw;
        if (!valid) begin
            r.reg_write = 1'b0;
            r.mem_write = 1'b0;
            r.branch    = 1'b0;
            r.jump      = 1'b0;
            r.jalr      = 1'b0;
        end else begin
            r = cw;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode/execute boundary bundle: decode-side values, hazard controls and the
// execute-side registered copies.
interface id_ex_reg_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 32
);
    import rv_pkg::*;

    logic                    StallE, FlushE;
    logic                    ValidD, RegWriteD, MemWriteD, BranchD, JumpD, JalrD, ALUSrcD;
    logic [RESULT_SRC_W-1:0] ResultSrcD;
    logic [ALU_CTRL_W-1:0]   ALUControlD;
    logic [FUNCT3_W-1:0]     Funct3D;
    logic [XLEN-1:0]         RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [REG_IDX_W-1:0]    Rs1D, Rs2D, RdD;

    logic                    ValidE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE;
    logic [RESULT_SRC_W-1:0] ResultSrcE;
    logic [ALU_CTRL_W-1:0]   ALUControlE;
    logic [FUNCT3_W-1:0]     Funct3E;
    logic [XLEN-1:0]         RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [REG_IDX_W-1:0]    Rs1E, Rs2E, RdE;
    logic [CNTW-1:0]         BubbleCount;

    modport master (
        output StallE, FlushE, ValidD, RegWriteD, MemWriteD, BranchD, JumpD, JalrD,
               ALUSrcD, ResultSrcD, ALUControlD, Funct3D, RD1D, RD2D, PCD, PCPlus4D,
               ImmExtD, Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
               ResultSrcE, ALUControlE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
               Rs1E, Rs2E, RdE, BubbleCount
    );

    modport slave (
        input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, BranchD, JumpD, JalrD,
               ALUSrcD, ResultSrcD, ALUControlD, Funct3D, RD1D, RD2D, PCD, PCPlus4D,
               ImmExtD, Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
               ResultSrcE, ALUControlE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
               Rs1E, Rs2E, RdE, BubbleCount
    );
endinterface

// File: rtl/id_ex_reg_pipe_field_reg.sv
// W-bit pipeline field register: synchronous reset, then clear, then enable.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Next value: clear beats load, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with hazard stall/flush and a count of
// inserted bubbles.
module id_ex_reg
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 32
) (
    input logic          clk,
    input logic          reset,
    id_ex_reg_if.slave   bus
);
    localparam int CTRL_W = $bits(ctrl_word_t) + FUNCT3_W + 1;
    localparam int DATA_W = 5 * XLEN;
    localparam int IDX_W  = 3 * REG_IDX_W;

    ctrl_word_t        ctrl_raw_s;
    ctrl_word_t        ctrl_gated_s;
    ctrl_word_t        ctrl_out_s;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idx_q;
    logic              load_en_s;
    logic [CNTW-1:0]   bubble_count_d;
    logic [CNTW-1:0]   bubble_count_q;

    assign load_en_s = ~bus.StallE;

    // Assemble the decode control word and neutralise it for invalid slots.
    always_comb begin
        ctrl_raw_s = '{reg_write:   bus.RegWriteD,
                       mem_write:   bus.MemWriteD,
                       branch:      bus.BranchD,
                       jump:        bus.JumpD,
                       jalr:        bus.JalrD,
                       alu_src:     bus.ALUSrcD,
                       result_src:  bus.ResultSrcD,
                       alu_control: bus.ALUControlD};
        ctrl_gated_s = gate_ctrl(ctrl_raw_s, bus.ValidD);
    end

    pipe_field_reg #(.W(CTRL_W)) u_ctrl (
        .clk(clk), .reset(reset), .clr(bus.FlushE), .en(load_en_s),
        .d({bus.ValidD, bus.Funct3D, ctrl_gated_s}),
        .q(ctrl_q)
    );

    pipe_field_reg #(.W(DATA_W)) u_data (
        .clk(clk), .reset(reset), .clr(bus.FlushE), .en(load_en_s),
        .d({bus.RD1D, bus.RD2D, bus.PCD, bus.PCPlus4D, bus.ImmExtD}),
        .q(data_q)
    );

    // Clearing indices on a flush keeps forwarding comparisons from matching.
    pipe_field_reg #(.W(IDX_W)) u_idx (
        .clk(clk), .reset(reset), .clr(bus.FlushE), .en(load_en_s),
        .d({bus.Rs1D, bus.Rs2D, bus.RdD}),
        .q(idx_q)
    );

    assign ctrl_out_s  = ctrl_q[$bits(ctrl_word_t)-1:0];
    assign bus.ValidE      = ctrl_q[CTRL_W-1];
    assign bus.Funct3E     = ctrl_q[CTRL_W-2 -: FUNCT3_W];
    assign bus.RegWriteE   = ctrl_out_s.reg_write;
    assign bus.MemWriteE   = ctrl_out_s.mem_write;
    assign bus.BranchE     = ctrl_out_s.branch;
    assign bus.JumpE       = ctrl_out_s.jump;
    assign bus.JalrE       = ctrl_out_s.jalr;
    assign bus.ALUSrcE     = ctrl_out_s.alu_src;
    assign bus.ResultSrcE  = ctrl_out_s.result_src;
    assign bus.ALUControlE = ctrl_out_s.alu_control;

    assign {bus.RD1E, bus.RD2E, bus.PCE, bus.PCPlus4E, bus.ImmExtE} = data_q;
    assign {bus.Rs1E, bus.Rs2E, bus.RdE} = idx_q;

    // Bubble counter advances once per flush, wrapping freely.
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (bus.FlushE) begin
            bubble_count_d = bubble_count_q + CNTW'(1);
        end else begin
            bubble_count_d = bubble_count_q;
        end
    end

    // Bubble counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count_q <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.BubbleCount = bubble_count_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for id_ex_reg, plus a bubble-counter wrap sequence.
module tb_id_ex_reg;
    localparam int XLEN = 32;
    localparam int CNTW = 4;

    localparam logic [31:0] C_RD2 = 32'hBEEF_0002;
    localparam logic [31:0] C_PC  = 32'h0000_0100;
    localparam logic [31:0] C_PC4 = 32'h0000_0104;
    localparam logic [31:0] C_IMM = 32'hFFFF_FFF0;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_ex_reg_if #(.XLEN(XLEN), .CNTW(CNTW)) bus ();

    id_ex_reg #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, flush, valid, rw, mw, jump;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic        e_rw, e_mw, e_jump, e_valid;
        logic [3:0]  e_alu;
        logic [4:0]  e_rd;
        logic [31:0] e_rd1;
        logic [3:0]  e_bc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.StallE = 1'b0;    bus.FlushE = 1'b0;
        bus.ValidD = 1'b1;    bus.RegWriteD = 1'b1; bus.MemWriteD = 1'b1;
        bus.BranchD = 1'b1;   bus.JumpD = 1'b1;     bus.JalrD = 1'b1;
        bus.ALUSrcD = 1'b1;   bus.ResultSrcD = 2'b10;
        bus.ALUControlD = 4'b0101; bus.Funct3D = 3'b101;
        bus.RD1D = 32'hAAAA_0001; bus.RD2D = C_RD2; bus.PCD = C_PC;
        bus.PCPlus4D = C_PC4;     bus.ImmExtD = C_IMM;
        bus.Rs1D = 5'd3; bus.Rs2D = 5'd4; bus.RdD = 5'd31;

        //          rst   stl   fl    vld   rw    mw    jmp   alu      rd     rd1            e_rw  e_mw  e_jmp e_vld e_alu    e_rd   e_rd1          bc
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,4'b0101,5'd31, 32'hAAAA_0001, 1'b0,1'b0,1'b0,1'b0,4'b0000,5'd0, 32'h0,         4'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0010,5'd5,  32'h0000_1234, 1'b1,1'b0,1'b0,1'b1,4'b0010,5'd5, 32'h0000_1234, 4'd0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0001,5'd9,  32'h0000_9999, 1'b1,1'b0,1'b0,1'b1,4'b0010,5'd5, 32'h0000_1234, 4'd0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0001,5'd9,  32'h0000_9999, 1'b1,1'b0,1'b0,1'b1,4'b0010,5'd5, 32'h0000_1234, 4'd0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0001,5'd9,  32'h0000_9999, 1'b1,1'b0,1'b0,1'b1,4'b0010,5'd5, 32'h0000_1234, 4'd0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0001,5'd9,  32'h0000_9999, 1'b1,1'b0,1'b0,1'b1,4'b0001,5'd9, 32'h0000_9999, 4'd0};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,4'b0011,5'd12, 32'h0000_5555, 1'b0,1'b0,1'b0,1'b0,4'b0000,5'd0, 32'h0,         4'd1};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,4'b0100,5'd7,  32'h0000_7777, 1'b0,1'b0,1'b0,1'b0,4'b0100,5'd7, 32'h0000_7777, 4'd1};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,5'd8,  32'h0000_8888, 1'b0,1'b0,1'b0,1'b0,4'b0000,5'd0, 32'h0,         4'd2};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,5'd8,  32'h0000_8888, 1'b0,1'b0,1'b0,1'b0,4'b0000,5'd0, 32'h0,         4'd3};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,4'b0110,5'd2,  32'h0000_2222, 1'b0,1'b0,1'b0,1'b0,4'b0000,5'd0, 32'h0,         4'd0};

        for (int i = 0; i < 11; i++) begin
            reset           = vecs[i].rst;
            bus.StallE      = vecs[i].stall;
            bus.FlushE      = vecs[i].flush;
            bus.ValidD      = vecs[i].valid;
            bus.RegWriteD   = vecs[i].rw;
            bus.MemWriteD   = vecs[i].mw;
            bus.JumpD       = vecs[i].jump;
            bus.ALUControlD = vecs[i].alu;
            bus.RdD         = vecs[i].rd;
            bus.RD1D        = vecs[i].rd1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d RegWriteE", i),   64'(bus.RegWriteE),   64'(vecs[i].e_rw));
            chk($sformatf("v%0d MemWriteE", i),   64'(bus.MemWriteE),   64'(vecs[i].e_mw));
            chk($sformatf("v%0d JumpE", i),       64'(bus.JumpE),       64'(vecs[i].e_jump));
            chk($sformatf("v%0d ValidE", i),      64'(bus.ValidE),      64'(vecs[i].e_valid));
            chk($sformatf("v%0d ALUControlE", i), 64'(bus.ALUControlE), 64'(vecs[i].e_alu));
            chk($sformatf("v%0d RdE", i),         64'(bus.RdE),         64'(vecs[i].e_rd));
            chk($sformatf("v%0d RD1E", i),        64'(bus.RD1E),        64'(vecs[i].e_rd1));
            chk($sformatf("v%0d BubbleCount", i), 64'(bus.BubbleCount), 64'(vecs[i].e_bc));
            if (vecs[i].rst || vecs[i].flush) begin
                chk($sformatf("v%0d other fields zero", i),
                    64'({bus.Rs1E, bus.Rs2E, bus.BranchE, bus.JalrE, bus.ALUSrcE,
                         bus.ResultSrcE, bus.Funct3E} | 64'(bus.RD2E | bus.PCE | bus.PCPlus4E | bus.ImmExtE)),
                    64'd0);
            end else if (!vecs[i].stall && !vecs[i].valid) begin
                chk($sformatf("v%0d branch/jalr gated", i), 64'({bus.BranchE, bus.JalrE}), 64'd0);
            end else if (!vecs[i].stall) begin
                chk($sformatf("v%0d passthrough", i),
                    64'({bus.Rs1E, bus.Rs2E, bus.BranchE, bus.JalrE, bus.ALUSrcE, bus.ResultSrcE, bus.Funct3E}),
                    64'({5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 2'b10, 3'b101}));
                chk($sformatf("v%0d data passthrough", i),
                    {bus.RD2E ^ C_RD2, bus.PCE ^ C_PC ^ bus.PCPlus4E ^ C_PC4 ^ bus.ImmExtE ^ C_IMM}, 64'd0);
            end
        end

        // Counter wrap: 16 flushes from reset, CNTW = 4.
        reset = 1'b1; bus.StallE = 1'b0; bus.FlushE = 1'b0;
        @(posedge clk); #1;
        chk("wrap reset", 64'(bus.BubbleCount), 64'd0);
        reset = 1'b0; bus.FlushE = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            chk($sformatf("wrap flush %0d", n), 64'(bus.BubbleCount), 64'(n % 16));
        end
        bus.FlushE = 1'b0;
        @(posedge clk); #1;
        chk("wrap hold", 64'(bus.BubbleCount), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
